// File: rtl/gpr_sb.sv
// General-purpose register file with a pending-write scoreboard.
// Tracks reserved destinations so issue logic can stall on busy sources.
module gpr_sb #(
  parameter int WordSize = 32,
  parameter int RegCount = 32,
  parameter int Bypass   = 1,
  localparam int AW      = $clog2(RegCount)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [AW-1:0]       rs1n,
  input  logic [AW-1:0]       rs2n,
  output logic [WordSize-1:0] rs1d,
  output logic [WordSize-1:0] rs2d,
  output logic                rs1_busy,
  output logic                rs2_busy,
  input  logic                wbe,
  input  logic [AW-1:0]       rdn,
  input  logic [WordSize-1:0] rdd,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_rdn,
  input  logic                flush,
  output logic [AW:0]         pend_cnt
);

  localparam logic [AW:0] CntMax = (AW+1)'(RegCount - 1);
  localparam bit          Byp    = (Bypass != 0);

  logic [WordSize-1:0] regs_q [RegCount];
  logic [WordSize-1:0] regs_d [RegCount];
  logic [RegCount-1:0] pend_q, pend_d;
  logic [AW:0]         cnt_q, cnt_d;

  logic wr_ok, is_ok, inc, dec;
  logic fwd1, fwd2;

  assign wr_ok = wbe && (rdn != '0);
  assign is_ok = iss_en && (iss_rdn != '0);
  assign fwd1  = Byp && wr_ok && (rdn == rs1n);
  assign fwd2  = Byp && wr_ok && (rdn == rs2n);

  // Set wins over clear on the same index, so that case never decrements.
  assign inc = is_ok && !pend_q[iss_rdn];
  assign dec = wr_ok && pend_q[rdn] &&
               !(is_ok && (iss_rdn == rdn));

  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    cnt_d  = cnt_q;
    if (wr_ok) regs_d[rdn] = rdd;
    if (flush) begin
      pend_d = '0;
      cnt_d  = '0;
    end else begin
      if (wr_ok) pend_d[rdn]     = 1'b0;
      if (is_ok) pend_d[iss_rdn] = 1'b1;
      if (inc && !dec && cnt_q != CntMax)
        cnt_d = cnt_q + 1'b1;
      else if (dec && !inc && cnt_q != '0)
        cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    rs1d     = (rs1n == '0) ? '0 : regs_q[rs1n];
    rs2d     = (rs2n == '0) ? '0 : regs_q[rs2n];
    rs1_busy = pend_q[rs1n];
    rs2_busy = pend_q[rs2n];
    if (fwd1) begin
      rs1d     = rdd;
      rs1_busy = 1'b0;
    end
    if (fwd2) begin
      rs2d     = rdd;
      rs2_busy = 1'b0;
    end
  end

  assign pend_cnt = cnt_q;

endmodule

// File: doc/gpr_sb.md
GPR_SB -- requirements
Module: gpr_sb

Interface
REQ-001 Parameter WordSize, default 32, data width of every register and data port.
REQ-002 Parameter RegCount, default 32, number of architectural registers; power of two, at least 2.
REQ-003 Parameter Bypass, default 1, enables same-cycle write-to-read forwarding (1) or disables it (0).
REQ-004 Derived constant AW = $clog2(RegCount), the width of every register index port.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  clock; all state updates on its rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 rs1n, rs2n  input  AW each  read-port register indices.
REQ-009 rs1d, rs2d  output  WordSize each  read-port data.
REQ-010 rs1_busy, rs2_busy  output  1 each  the indexed register has an outstanding reserved write.
REQ-011 wbe  input  1  writeback enable.
REQ-012 rdn  input  AW  writeback register index.
REQ-013 rdd  input  WordSize  writeback data.
REQ-014 iss_en  input  1  issue: reserve a destination register.
REQ-015 iss_rdn  input  AW  register index to reserve.
REQ-016 flush  input  1  clears all reservations.
REQ-017 pend_cnt  output  AW+1  registered count of currently reserved registers.

Function
REQ-018 Register 0 SHALL always read 0, SHALL ignore writes, and SHALL never be reserved or report busy.
REQ-019 When wbe=1 and rdn!=0, registers[rdn] SHALL take the value of rdd at the next clock edge.
REQ-020 Reads SHALL be combinational: rsXd = registers[rsXn], with rsXd = 0 whenever rsXn = 0.
REQ-021 When Bypass=1, wbe=1, rdn!=0 and rdn=rsXn, rsXd SHALL equal rdd in the same cycle.
REQ-022 When Bypass=0, rsXd SHALL show the old register value until the edge after the write.
REQ-023 Each register 1..RegCount-1 SHALL have a pending bit; rsX_busy SHALL equal pending[rsXn].
REQ-024 When Bypass=1, rsX_busy SHALL be forced to 0 whenever REQ-021 forwarding applies.
REQ-025 iss_en=1 with iss_rdn!=0 SHALL set pending[iss_rdn] at the next edge.
REQ-026 wbe=1 with rdn!=0 SHALL clear pending[rdn] at the next edge.
REQ-027 If iss_en and wbe target the same nonzero index in the same cycle, the set SHALL win (new producer), and the data SHALL still be written.
REQ-028 A writeback to a register that is not pending SHALL write the data and leave pending unchanged at 0.
REQ-029 flush=1 SHALL clear all pending bits at the next edge and SHALL take priority over a simultaneous iss_en; a simultaneous wbe data write SHALL still occur.
REQ-030 pend_cnt SHALL equal the number of set pending bits after each edge, updated each cycle by +1, -1, 0, or reset to 0 on flush.
REQ-031 pend_cnt SHALL saturate at RegCount-1 and SHALL never underflow.

Reset
REQ-032 While rst=1 at a clock edge, all registers SHALL become 0, all pending bits SHALL become 0, and pend_cnt SHALL become 0.
REQ-033 rst SHALL take priority over wbe, iss_en, and flush in the same cycle.
REQ-034 After reset, rsXd SHALL be 0 (except under REQ-021), rsX_busy SHALL be 0, and pend_cnt SHALL be 0.
REQ-035 Before the first reset, the contents of registers and pending bits are undefined.

Verification
REQ-036 Reset then wbe, rdn=5, rdd=0xDEADBEEF; next cycle rs1n=5, rs2n=5 -> rs1d=rs2d=0xDEADBEEF (checks independent ports).
REQ-037 wbe, rdn=0, rdd=0x1234 -> rs1n=0 reads 0; iss_en with iss_rdn=0 -> pend_cnt stays 0.
REQ-038 Bypass=1: wbe, rdn=7, rdd=0xA5, with rs2n=7 in the same cycle -> rs2d=0xA5 and rs2_busy=0; Bypass=0 -> rs2d shows the old value.
REQ-039 iss_en to register 3 -> next cycle rs1_busy=1 and pend_cnt=1; same-cycle iss_en and wbe to register 3 -> still busy and data written; wbe alone to 3 -> busy=0 and pend_cnt=0.
REQ-040 Reserve registers 1, 2, 4 (pend_cnt=3), then flush together with iss_en to register 6 -> all busy=0 and pend_cnt=0.
REQ-041 rst asserted mid-stream while registers are pending and iss_en=1 -> next cycle all reads 0, all busy=0, and pend_cnt=0.
